lstm_sample_sequencer: RTL and testbench

//   Synthesizable front/back-end for the LSTM network core. Buffers input vectors in a FIFO
//   and issues each one with a single-cycle newSample pulse. Waits for the core's dataReady,

---
 rtl/lstm_sample_sequencer_pkg.sv | 44 ++++
 rtl/lstm_sample_sequencer_if.sv | 43 ++++
 rtl/lstm_sample_sequencer_sync_fifo.sv | 61 ++++++
 rtl/lstm_sample_sequencer.sv | 153 +++++++++++++++
 tb/tb_lstm_sample_sequencer.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lstm_sample_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lstm_sample_sequencer_pkg
// Brief    : Shared types, defaults and helpers for the LSTM sample sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package lstm_sample_sequencer_pkg;

    localparam int DEF_INPUT_SZ   = 2;
    localparam int DEF_HIDDEN_SZ  = 8;
    localparam int DEF_QN         = 6;
    localparam int DEF_QM         = 11;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_TIMEOUT    = 4096;

    // Sequencer states, 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    // Bits needed to hold the values 0..v-1
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Total word width of a signed Q(qn).(qm) value
    function automatic int bitwidth(input int qn, input int qm);
        return qn + qm + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lstm_sample_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : lstm_sample_sequencer_if
// Brief    : Input stream, core handshake and output stream of the sequencer.
//            master = sequencer view, slave = environment view.
// Revision : 1.0 - initial release
// ============================================================================
interface lstm_sample_sequencer_if
    import lstm_sample_sequencer_pkg::*;
#(
    parameter int INPUT_SZ  = DEF_INPUT_SZ,
    parameter int HIDDEN_SZ = DEF_HIDDEN_SZ,
    parameter int BITWIDTH  = bitwidth(DEF_QN, DEF_QM),
    parameter int IDX_W     = clog2(HIDDEN_SZ)
) ();
    logic                            s_valid;
    logic                            s_ready;
    logic [INPUT_SZ*BITWIDTH-1:0]    s_data;
    logic                            s_last;
    logic [INPUT_SZ*BITWIDTH-1:0]    net_inputVec;
    logic                            net_newSample;
    logic                            net_clearState;
    logic                            net_dataReady;
    logic [HIDDEN_SZ*BITWIDTH-1:0]   net_outputVec;
    logic                            m_valid;
    logic                            m_ready;
    logic [BITWIDTH-1:0]             m_data;
    logic [IDX_W-1:0]                m_index;
    logic                            m_last;

    modport master (
        input  s_valid, s_data, s_last, net_dataReady, net_outputVec, m_ready,
        output s_ready, net_inputVec, net_newSample, net_clearState,
               m_valid, m_data, m_index, m_last
    );

    modport slave (
        output s_valid, s_data, s_last, net_dataReady, net_outputVec, m_ready,
        input  s_ready, net_inputVec, net_newSample, net_clearState,
               m_valid, m_data, m_index, m_last
    );
endinterface
`default_nettype wire

// File: rtl/lstm_sample_sequencer_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : lstm_sample_sequencer_sync_fifo
// Brief    : Single-clock FIFO with full/empty flags, no write-to-read bypass.
// Revision : 1.0 - initial release
// ============================================================================
module lstm_sample_sequencer_sync_fifo
    import lstm_sample_sequencer_pkg::*;
#(
    parameter int WIDTH = 37,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             wr_en,
    input  wire logic [WIDTH-1:0] wr_data,
    input  wire logic             rd_en,
    output logic      [WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push;
    logic             pop;

    // Pointers carry one wrap bit so full and empty are distinguishable
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer values
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // Pointer registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
endmodule
`default_nettype wire

// File: rtl/lstm_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lstm_sample_sequencer
// Brief    : Buffers input vectors, issues them to the LSTM core one at a
//            time, serialises the core result as one beat per neuron and
//            pulses a state clear at each sequence boundary.
// Revision : 1.0 - initial release
// ============================================================================
module lstm_sample_sequencer
    import lstm_sample_sequencer_pkg::*;
#(
    parameter int INPUT_SZ   = DEF_INPUT_SZ,
    parameter int HIDDEN_SZ  = DEF_HIDDEN_SZ,
    parameter int QN         = DEF_QN,
    parameter int QM         = DEF_QM,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  wire logic                clock,
    input  wire logic                reset,
    lstm_sample_sequencer_if.master  bus,
    output logic                     busy,
    output logic                     err_timeout
);
    localparam int BITWIDTH = bitwidth(QN, QM);
    localparam int VEC_W    = INPUT_SZ * BITWIDTH;
    localparam int OUT_W    = HIDDEN_SZ * BITWIDTH;
    localparam int IDX_W    = clog2(HIDDEN_SZ);
    localparam int CNT_W    = clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   in_vec_q, in_vec_d;
    logic               last_q, last_d;
    logic [OUT_W-1:0]   shadow_q, shadow_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               dr_prev_q, dr_prev_d;

    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [VEC_W:0]     fifo_rd;
    logic               dr_edge;

    // Each entry carries the vector plus its end-of-sequence flag in the MSB
    lstm_sample_sequencer_sync_fifo #(
        .WIDTH (VEC_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (bus.s_valid),
        .wr_data ({bus.s_last, bus.s_data}),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A level held high from an earlier sample is not a new result
    assign dr_edge   = bus.net_dataReady && !dr_prev_q;
    assign dr_prev_d = bus.net_dataReady;

    assign bus.s_ready        = !fifo_full;
    assign bus.net_inputVec   = in_vec_q;
    assign bus.net_newSample  = (state_q == ST_ISSUE);
    assign bus.net_clearState = (state_q == ST_CLEAR);
    assign bus.m_valid        = (state_q == ST_DRAIN);
    assign bus.m_data         = shadow_q[int'(idx_q)*BITWIDTH +: BITWIDTH];
    assign bus.m_index        = idx_q;
    assign bus.m_last         = (state_q == ST_DRAIN) && last_q &&
                                (idx_q == IDX_W'(HIDDEN_SZ - 1));
    assign busy               = (state_q != ST_IDLE) || !fifo_empty;
    assign err_timeout        = err_q;

    // Sequencer next-state and datapath updates
    always_comb begin
        state_d  = state_q;
        in_vec_d = in_vec_q;
        last_d   = last_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    in_vec_d = fifo_rd[VEC_W-1:0];
                    last_d   = fifo_rd[VEC_W];
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (dr_edge) begin
                    shadow_d = bus.net_outputVec;
                    idx_d    = '0;
                    state_d  = ST_DRAIN;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (bus.m_ready) begin
                    if (idx_q == IDX_W'(HIDDEN_SZ - 1)) begin
                        state_d = last_q ? ST_CLEAR : ST_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers; reset abandons any sample in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            in_vec_q  <= '0;
            last_q    <= 1'b0;
            shadow_q  <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            dr_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_vec_q  <= in_vec_d;
            last_q    <= last_d;
            shadow_q  <= shadow_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            dr_prev_q <= dr_prev_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_lstm_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lstm_sample_sequencer
// Brief    : Directed bench for lstm_sample_sequencer with a simple core model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lstm_sample_sequencer;
    localparam int BW     = 18;
    localparam int VEC_W  = 2 * BW;
    localparam int OUT_W  = 8 * BW;
    localparam int HID    = 8;

    typedef struct {
        logic [BW-1:0] x0;
        logic [BW-1:0] x1;
        logic          last;
        logic          exp_mlast;
        logic          exp_clear;
    } vec_t;

    logic clock;
    logic reset;
    logic busy;
    logic err_timeout;

    int checks;
    int errors;
    int clear_cnt;
    int core_cnt;
    int core_delay;
    bit core_hold;
    logic [VEC_W-1:0] core_vec;
    vec_t tbl [5];

    lstm_sample_sequencer_if #(.INPUT_SZ(2), .HIDDEN_SZ(8), .BITWIDTH(BW)) bus ();

    lstm_sample_sequencer #(
        .INPUT_SZ   (2),
        .HIDDEN_SZ  (8),
        .QN         (6),
        .QM         (11),
        .FIFO_DEPTH (4),
        .TIMEOUT    (64)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Stand-in core result: distinct per neuron, derived from the input
    function automatic logic [OUT_W-1:0] model(input logic [VEC_W-1:0] x);
        logic [OUT_W-1:0] o;
        o = '0;
        for (int k = 0; k < HID; k++)
            o[k*BW +: BW] = x[BW-1:0] ^ x[2*BW-1:BW] ^ BW'(k * 32'h1234);
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Core model: raises dataReady core_delay cycles after newSample
    initial begin
        core_cnt = 0;
        bus.net_dataReady = 1'b0;
        bus.net_outputVec = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                core_cnt = 0;
                bus.net_dataReady = 1'b0;
            end else begin
                if (core_cnt != 0) begin
                    core_cnt--;
                    if (core_cnt == 0) begin
                        bus.net_outputVec = model(core_vec);
                        bus.net_dataReady = 1'b1;
                    end
                end else if (bus.net_dataReady && !core_hold) begin
                    bus.net_dataReady = 1'b0;
                end
                if (bus.net_newSample) begin
                    core_vec = bus.net_inputVec;
                    core_cnt = core_delay;
                end
            end
        end
    end

    initial begin
        clear_cnt = 0;
        forever begin
            @(negedge clock);
            if (bus.net_clearState) clear_cnt++;
        end
    end

    task automatic push(input logic [VEC_W-1:0] x, input logic last);
        bus.s_valid = 1'b1;
        bus.s_data  = x;
        bus.s_last  = last;
        @(negedge clock);
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_issue(input logic [VEC_W-1:0] x, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.net_newSample && n < 200);
        check("issue_seen", 64'(bus.net_newSample), 64'd1);
        check("inputVec", 64'(bus.net_inputVec), 64'(x));
        @(negedge clock);
        check("newSample_width", 64'(bus.net_newSample), 64'd0);
    endtask

    // mode 0: always ready; mode 1: ready pattern 1,0,0,1 over valid cycles
    task automatic drain(input logic [VEC_W-1:0] x, input logic last, input int mode,
                         input int stop_at, output bit stopped);
        logic [OUT_W-1:0] exp;
        int idx;
        int vcyc;
        int cyc;
        exp = model(x);
        idx = 0;
        vcyc = 0;
        cyc = 0;
        stopped = 1'b0;
        while (idx < HID && cyc < 400) begin
            if (mode == 1) bus.m_ready = ((vcyc % 4) == 0) || ((vcyc % 4) == 3);
            else           bus.m_ready = 1'b1;
            if (bus.m_valid) begin
                check("m_index", 64'(bus.m_index), 64'(idx));
                check("m_data", 64'(bus.m_data), 64'(exp[idx*BW +: BW]));
                check("m_last", 64'(bus.m_last), 64'(last && idx == HID - 1));
                if (stop_at == idx) begin
                    stopped = 1'b1;
                    return;
                end
                if (bus.m_ready) idx++;
                vcyc++;
            end
            cyc++;
            if (idx < HID) @(negedge clock);
        end
        check("drain_complete", 64'(idx), 64'(HID));
        bus.m_ready = 1'b1;
    endtask

    initial begin
        int n;
        bit stp;
        int clr0;
        int ns_seen;
        logic [VEC_W-1:0] xa;

        checks = 0;
        errors = 0;
        core_delay = 20;
        core_hold = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;

        tbl[0] = '{x0: 18'h00800, x1: 18'h3F800, last: 1'b0, exp_mlast: 1'b0, exp_clear: 1'b0};
        tbl[1] = '{x0: 18'h12345, x1: 18'h2ABCD, last: 1'b0, exp_mlast: 1'b0, exp_clear: 1'b0};
        tbl[2] = '{x0: 18'h3FFFF, x1: 18'h00001, last: 1'b0, exp_mlast: 1'b0, exp_clear: 1'b0};
        tbl[3] = '{x0: 18'h20000, x1: 18'h1F0F0, last: 1'b0, exp_mlast: 1'b0, exp_clear: 1'b0};
        tbl[4] = '{x0: 18'h0A5A5, x1: 18'h35A5A, last: 1'b1, exp_mlast: 1'b1, exp_clear: 1'b1};

        // 1. reset
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_s_ready", 64'(bus.s_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_newSample", 64'(bus.net_newSample), 64'd0);
        check("rst_clearState", 64'(bus.net_clearState), 64'd0);
        check("rst_m_valid", 64'(bus.m_valid), 64'd0);
        check("rst_err", 64'(err_timeout), 64'd0);
        check("rst_inputVec", 64'(bus.net_inputVec), 64'd0);

        // 2. single sample, latency and full drain
        bus.m_ready = 1'b1;
        xa = {18'h3F800, 18'h00800};
        clr0 = clear_cnt;
        push(xa, 1'b0);
        check("t2_no_newSample_at_pop", 64'(bus.net_newSample), 64'd0);
        wait_issue(xa, n);
        check("t2_issue_latency", 64'(n), 64'd1);
        repeat (19) @(negedge clock);
        check("t2_not_valid_yet", 64'(bus.m_valid), 64'd0);
        @(negedge clock);
        check("t2_first_beat_valid", 64'(bus.m_valid), 64'd1);
        drain(xa, 1'b0, 0, -1, stp);
        @(negedge clock);
        check("t2_clear", 64'(bus.net_clearState), 64'd0);
        check("t2_valid_end", 64'(bus.m_valid), 64'd0);
        check("t2_no_clear_pulse", 64'(clear_cnt - clr0), 64'd0);

        // 3. table-driven: fill FIFO while sample 0 waits, then drain in order
        clr0 = clear_cnt;
        push({tbl[0].x1, tbl[0].x0}, tbl[0].last);
        wait_issue({tbl[0].x1, tbl[0].x0}, n);
        for (int i = 1; i < 5; i++) push({tbl[i].x1, tbl[i].x0}, tbl[i].last);
        check("t3_full_s_ready", 64'(bus.s_ready), 64'd0);
        check("t3_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) wait_issue({tbl[i].x1, tbl[i].x0}, n);
            drain({tbl[i].x1, tbl[i].x0}, tbl[i].exp_mlast, 0, -1, stp);
            @(negedge clock);
            check("t3_clear", 64'(bus.net_clearState), 64'(tbl[i].exp_clear));
        end
        @(negedge clock);
        check("t3_clear_once", 64'(clear_cnt - clr0), 64'd1);
        check("t3_idle", 64'(busy), 64'd0);

        // 4. stalled drain
        xa = {18'h11111, 18'h2EEEE};
        push(xa, 1'b0);
        wait_issue(xa, n);
        drain(xa, 1'b0, 1, -1, stp);
        @(negedge clock);
        check("t4_clear", 64'(bus.net_clearState), 64'd0);

        // 5. dataReady held high: second sample never sees an edge
        core_hold = 1'b1;
        xa = {18'h00123, 18'h00456};
        push(xa, 1'b0);
        wait_issue(xa, n);
        drain(xa, 1'b0, 0, -1, stp);
        @(negedge clock);
        xa = {18'h0ABCD, 18'h01234};
        push(xa, 1'b0);
        wait_issue(xa, n);
        repeat (63) @(negedge clock);
        check("t5_err_before", 64'(err_timeout), 64'd0);
        check("t5_busy_waiting", 64'(busy), 64'd1);
        @(negedge clock);
        check("t5_err_set", 64'(err_timeout), 64'd1);
        check("t5_idle", 64'(busy), 64'd0);
        check("t5_no_valid", 64'(bus.m_valid), 64'd0);
        core_hold = 1'b0;
        repeat (3) @(negedge clock);
        check("t5_err_sticky", 64'(err_timeout), 64'd1);

        // 6. reset in the middle of a drain
        xa = {18'h3C3C3, 18'h03C3C};
        push(xa, 1'b0);
        wait_issue(xa, n);
        push({18'h15555, 18'h2AAAA}, 1'b1);
        drain(xa, 1'b0, 0, 3, stp);
        check("t6_reached_idx3", 64'(stp), 64'd1);
        reset = 1'b0;
        #1;
        check("t6_rst_m_valid", 64'(bus.m_valid), 64'd0);
        check("t6_rst_m_data", 64'(bus.m_data), 64'd0);
        check("t6_rst_m_index", 64'(bus.m_index), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_err", 64'(err_timeout), 64'd0);
        check("t6_rst_inputVec", 64'(bus.net_inputVec), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        ns_seen = 0;
        clr0 = clear_cnt;
        repeat (4) begin
            @(negedge clock);
            if (bus.net_newSample) ns_seen++;
        end
        check("t6_fifo_flushed", 64'(ns_seen), 64'd0);
        check("t6_no_clear", 64'(clear_cnt - clr0), 64'd0);
        xa = {18'h01010, 18'h20202};
        push(xa, 1'b1);
        wait_issue(xa, n);
        check("t6_issue_latency", 64'(n), 64'd1);
        drain(xa, 1'b1, 0, -1, stp);
        @(negedge clock);
        check("t6_clear", 64'(bus.net_clearState), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
